// File: rtl/bkm_data_step_driver_if.sv
// -----------------------------------------------------------------------------
// bkm_data_step_driver_if
// Vector stream between the bench vector source (master) and the
// bkm_data_step_driver (slave). One vector = control fields, operands and the
// expected results; transferred when vec_valid && vec_ready at a clk edge.
//   vec_valid                        master -> slave  vector present
//   vec_ready                        slave  -> master driver can accept
//   vec_mode/format/n/d_x_n/d_y_n    master -> slave  control fields
//   vec_X_n/Y_n                      master -> slave  operands
//   vec_X_np1/Y_np1                  master -> slave  expected results
// -----------------------------------------------------------------------------
interface bkm_data_step_driver_if #(
    parameter int W     = 64,
    parameter int LOG2N = 6
);
    logic             vec_valid;
    logic             vec_ready;
    logic             vec_mode;
    logic [1:0]       vec_format;
    logic [LOG2N-1:0] vec_n;
    logic [1:0]       vec_d_x_n;
    logic [1:0]       vec_d_y_n;
    logic [W-1:0]     vec_X_n;
    logic [W-1:0]     vec_Y_n;
    logic [W-1:0]     vec_X_np1;
    logic [W-1:0]     vec_Y_np1;

    modport master (
        output vec_valid, vec_mode, vec_format, vec_n, vec_d_x_n, vec_d_y_n,
               vec_X_n, vec_Y_n, vec_X_np1, vec_Y_np1,
        input  vec_ready
    );

    modport slave (
        input  vec_valid, vec_mode, vec_format, vec_n, vec_d_x_n, vec_d_y_n,
               vec_X_n, vec_Y_n, vec_X_np1, vec_Y_np1,
        output vec_ready
    );
endinterface

// File: rtl/bkm_data_step_driver.sv
// -----------------------------------------------------------------------------
// bkm_data_step_driver
// Stimulus-side companion to the bkm_data_step checker. Buffers incoming test
// vectors in a DEPTH-entry FIFO, issues their operands to the DUT with a
// programmable idle gap, and delays the expected results by the DUT latency so
// they reach the checker in the same cycle as the DUT result.
//   clk, arst (async, active-low), srst (sync, active-high)
//   enable                 global advance enable shared with DUT/checker
//   vec                    vector stream (slave side)
//   gap                    idle enabled cycles after each issue
//   tb_* / dut_valid       registered operand drive + one-cycle issue pulse
//   tb_X_np1/Y_np1         expected results aligned to the DUT output
//   chk_enable             expected and DUT result are valid this cycle
//   busy                   any vector buffered, gapping or in flight
//   issued_cnt/checked_cnt saturating vector counters
// -----------------------------------------------------------------------------
module bkm_data_step_driver #(
    parameter int W     = 64,
    parameter int LOG2N = 6,
    parameter int DEPTH = 4,
    parameter int LAT   = 1,
    parameter int GAPW  = 4
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         srst,
    input  logic                         enable,
    bkm_data_step_driver_if.slave        vec,
    input  logic [GAPW-1:0]              gap,
    output logic                         tb_mode,
    output logic [1:0]                   tb_format,
    output logic [LOG2N-1:0]             tb_n,
    output logic [1:0]                   tb_d_x_n,
    output logic [1:0]                   tb_d_y_n,
    output logic [W-1:0]                 tb_X_n,
    output logic [W-1:0]                 tb_Y_n,
    output logic                         dut_valid,
    output logic [W-1:0]                 tb_X_np1,
    output logic [W-1:0]                 tb_Y_np1,
    output logic                         chk_enable,
    output logic                         busy,
    output logic [15:0]                  issued_cnt,
    output logic [15:0]                  checked_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic             mode;
        logic [1:0]       format;
        logic [LOG2N-1:0] n;
        logic [1:0]       d_x_n;
        logic [1:0]       d_y_n;
        logic [W-1:0]     x_n;
        logic [W-1:0]     y_n;
        logic [W-1:0]     x_np1;
        logic [W-1:0]     y_np1;
    } vec_t;

    typedef enum logic {IDLE, GAP} state_t;

    vec_t             fifo_mem [DEPTH];
    vec_t             wr_vec;
    vec_t             head;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    state_t           state_q;
    logic [GAPW-1:0]  gap_cnt_q;
    vec_t             iss_q;          // last issued vector (drives tb_*)
    logic             dut_valid_q;
    logic             pend_v_q;       // issued, not yet captured by the DUT
    logic [LAT-1:0]   dl_v_q;
    logic [W-1:0]     dl_x_q [LAT];
    logic [W-1:0]     dl_y_q [LAT];
    logic [15:0]      issued_cnt_q, checked_cnt_q;

    logic full, empty, push, issue, chk;

    assign wr_vec = '{mode:  vec.vec_mode,  format: vec.vec_format, n: vec.vec_n,
                      d_x_n: vec.vec_d_x_n, d_y_n:  vec.vec_d_y_n,
                      x_n:   vec.vec_X_n,   y_n:    vec.vec_Y_n,
                      x_np1: vec.vec_X_np1, y_np1:  vec.vec_Y_np1};
    assign head   = fifo_mem[rd_ptr_q];

    // No full-bypass: a pop in the same cycle does not open vec_ready.
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign push   = vec.vec_valid && !full;
    assign issue  = (state_q == IDLE) && enable && !empty;
    assign chk    = dl_v_q[LAT-1] && enable;

    // NOTE: the FIFO storage is not reset; the pointers and count alone define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= wr_vec;
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            gap_cnt_q     <= '0;
            iss_q         <= '0;
            dut_valid_q   <= 1'b0;
            pend_v_q      <= 1'b0;
            dl_v_q        <= '0;
            for (int i = 0; i < LAT; i++) begin
                dl_x_q[i] <= '0;
                dl_y_q[i] <= '0;
            end
            issued_cnt_q  <= '0;
            checked_cnt_q <= '0;
        end else if (srst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            gap_cnt_q     <= '0;
            iss_q         <= '0;
            dut_valid_q   <= 1'b0;
            pend_v_q      <= 1'b0;
            dl_v_q        <= '0;
            for (int i = 0; i < LAT; i++) begin
                dl_x_q[i] <= '0;
                dl_y_q[i] <= '0;
            end
            issued_cnt_q  <= '0;
            checked_cnt_q <= '0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(issue);

            dut_valid_q <= issue;
            if (issue) iss_q <= head;

            unique case (state_q)
                IDLE: begin
                    // gap is sampled only here, at issue time.
                    if (issue && gap != '0) begin
                        state_q   <= GAP;
                        gap_cnt_q <= gap;
                    end
                end
                GAP: begin
                    if (enable) begin
                        if (gap_cnt_q == GAPW'(1)) state_q <= IDLE;
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // The DUT captures tb_* at the enabled edge after the issue; that
            // capture is what enters stage 0, so the last stage lines up with
            // the DUT's LAT-th registered stage.
            if (enable) begin
                pend_v_q  <= issue;
                dl_v_q[0] <= pend_v_q;
                dl_x_q[0] <= iss_q.x_np1;
                dl_y_q[0] <= iss_q.y_np1;
                for (int i = 1; i < LAT; i++) begin
                    dl_v_q[i] <= dl_v_q[i-1];
                    dl_x_q[i] <= dl_x_q[i-1];
                    dl_y_q[i] <= dl_y_q[i-1];
                end
            end

            if (issue && issued_cnt_q != 16'hFFFF)
                issued_cnt_q <= issued_cnt_q + 16'd1;
            if (chk && checked_cnt_q != 16'hFFFF)
                checked_cnt_q <= checked_cnt_q + 16'd1;
        end
    end

    assign vec.vec_ready = !full;
    assign tb_mode       = iss_q.mode;
    assign tb_format     = iss_q.format;
    assign tb_n          = iss_q.n;
    assign tb_d_x_n      = iss_q.d_x_n;
    assign tb_d_y_n      = iss_q.d_y_n;
    assign tb_X_n        = iss_q.x_n;
    assign tb_Y_n        = iss_q.y_n;
    assign dut_valid     = dut_valid_q;
    assign tb_X_np1      = dl_x_q[LAT-1];
    assign tb_Y_np1      = dl_y_q[LAT-1];
    assign chk_enable    = chk;
    assign busy          = !empty || (state_q != IDLE) || pend_v_q || (|dl_v_q);
    assign issued_cnt    = issued_cnt_q;
    assign checked_cnt   = checked_cnt_q;
endmodule

// File: tb/tb_bkm_data_step_driver.sv
// -----------------------------------------------------------------------------
// tb_bkm_data_step_driver
// Bench for bkm_data_step_driver. A queue-based model predicts every output
// each cycle; directed sections pin the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_bkm_data_step_driver;
    localparam int W = 64, LOG2N = 6, DEPTH = 4, LAT = 1, GAPW = 4;

    typedef struct packed {
        logic             mode;
        logic [1:0]       format;
        logic [LOG2N-1:0] n;
        logic [1:0]       dx;
        logic [1:0]       dy;
        logic [W-1:0]     xn;
        logic [W-1:0]     yn;
        logic [W-1:0]     xn1;
        logic [W-1:0]     yn1;
    } vec_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           rem;   // enabled edges until shown to the checker
    } exp_t;

    logic clk = 1'b0;
    logic arst, srst, enable, vec_valid;
    logic [GAPW-1:0] gap;
    vec_t drv;

    logic             tb_mode, dut_valid, chk_enable, busy;
    logic [1:0]       tb_format, tb_d_x_n, tb_d_y_n;
    logic [LOG2N-1:0] tb_n;
    logic [W-1:0]     tb_X_n, tb_Y_n, tb_X_np1, tb_Y_np1;
    logic [15:0]      issued_cnt, checked_cnt;

    bkm_data_step_driver_if #(.W(W), .LOG2N(LOG2N)) vif ();
    assign vif.vec_valid  = vec_valid;
    assign vif.vec_mode   = drv.mode;
    assign vif.vec_format = drv.format;
    assign vif.vec_n      = drv.n;
    assign vif.vec_d_x_n  = drv.dx;
    assign vif.vec_d_y_n  = drv.dy;
    assign vif.vec_X_n    = drv.xn;
    assign vif.vec_Y_n    = drv.yn;
    assign vif.vec_X_np1  = drv.xn1;
    assign vif.vec_Y_np1  = drv.yn1;

    bkm_data_step_driver #(.W(W), .LOG2N(LOG2N), .DEPTH(DEPTH), .LAT(LAT), .GAPW(GAPW)) dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable), .vec(vif), .gap(gap),
        .tb_mode(tb_mode), .tb_format(tb_format), .tb_n(tb_n), .tb_d_x_n(tb_d_x_n),
        .tb_d_y_n(tb_d_y_n), .tb_X_n(tb_X_n), .tb_Y_n(tb_Y_n), .dut_valid(dut_valid),
        .tb_X_np1(tb_X_np1), .tb_Y_np1(tb_Y_np1), .chk_enable(chk_enable), .busy(busy),
        .issued_cnt(issued_cnt), .checked_cnt(checked_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    vec_t        m_fifo[$];
    exp_t        m_inf[$];
    int          m_wait;        // enabled cycles still to idle before next issue
    logic        m_dv;
    vec_t        m_last;
    logic [15:0] m_issued, m_checked;

    always @(posedge clk or negedge arst) begin
        bit   iss, rdy;
        vec_t hv;
        if (!arst || srst) begin
            m_fifo.delete();
            m_inf.delete();
            m_wait = 0; m_dv = 1'b0; m_last = '0;
            m_issued = '0; m_checked = '0;
        end else begin
            rdy = (m_fifo.size() < DEPTH);
            iss = enable && (m_wait == 0) && (m_fifo.size() > 0);
            if (enable) begin
                if (m_inf.size() > 0 && m_inf[0].rem == 0) begin
                    void'(m_inf.pop_front());
                    if (m_checked != 16'hFFFF) m_checked++;
                end
                foreach (m_inf[i]) m_inf[i].rem--;
                if (m_wait > 0) m_wait--;
            end
            if (iss) begin
                hv = m_fifo.pop_front();
                m_last = hv;
                m_inf.push_back('{hv.xn1, hv.yn1, LAT});
                m_wait = int'(gap);
                if (m_issued != 16'hFFFF) m_issued++;
            end
            m_dv = iss;
            if (vec_valid && rdy) m_fifo.push_back(drv);
        end
    end

    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        bit ec;
        if (cmp_on) begin
            ec = enable && (m_inf.size() > 0) && (m_inf[0].rem == 0);
            check("vec_ready", vif.vec_ready, m_fifo.size() < DEPTH);
            check("dut_valid", dut_valid, m_dv);
            check("tb_ctrl", {tb_mode, tb_format, tb_n, tb_d_x_n, tb_d_y_n},
                  {m_last.mode, m_last.format, m_last.n, m_last.dx, m_last.dy});
            check("tb_X_n", tb_X_n, m_last.xn);
            check("tb_Y_n", tb_Y_n, m_last.yn);
            check("chk_enable", chk_enable, ec);
            if (ec) begin
                check("tb_X_np1", tb_X_np1, m_inf[0].x);
                check("tb_Y_np1", tb_Y_np1, m_inf[0].y);
            end
            check("busy", busy, (m_fifo.size() > 0) || (m_wait > 0) || (m_inf.size() > 0));
            check("issued_cnt", issued_cnt, m_issued);
            check("checked_cnt", checked_cnt, m_checked);
        end
    end

    // ---------------- stimulus helpers ----------------
    vec_t sent_q[$];

    function automatic vec_t rand_vec();
        vec_t v;
        v.mode   = 1'($urandom);
        v.format = 2'($urandom);
        v.n      = LOG2N'($urandom);
        v.dx     = 2'($urandom);
        v.dy     = 2'($urandom);
        v.xn     = {$urandom, $urandom};
        v.yn     = {$urandom, $urandom};
        v.xn1    = {$urandom, $urandom};
        v.yn1    = {$urandom, $urandom};
        return v;
    endfunction

    // Entered and left at posedge+#1; vec_valid stays high across the vectors.
    task automatic send(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            drv = rand_vec();
            sent_q.push_back(drv);
            vec_valid = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 500 && !acc; k++) begin
                @(negedge clk);
                acc = vif.vec_ready;
                @(posedge clk); #1;
            end
            check("send_accept", acc, 1'b1);
        end
        vec_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("drain_idle", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   pulses[$];
        logic [W-1:0] hold_x;

        arst = 1'b0; srst = 1'b0; enable = 1'b0; vec_valid = 1'b0;
        gap = '0; drv = '0;
        #1 cmp_on = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_vec_ready", vif.vec_ready, 1'b1);
        check("rst_dut_valid", dut_valid, 1'b0);
        check("rst_chk", chk_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", {issued_cnt, checked_cnt}, 32'd0);
        check("rst_x", tb_X_n | tb_X_np1, 64'd0);

        // Single vector, LAT=1, gap=0.
        @(posedge clk); #1;
        arst = 1'b1; enable = 1'b1;
        drv = '0; drv.xn = 64'd5; drv.xn1 = 64'd7; vec_valid = 1'b1;
        @(posedge clk); #1 vec_valid = 1'b0;
        @(negedge clk); check("t1_no_issue_yet", dut_valid, 1'b0);
        @(negedge clk); check("t1_issue", dut_valid, 1'b1);
        check("t1_x_n", tb_X_n, 64'd5);
        check("t1_chk_not_yet", chk_enable, 1'b0);
        @(negedge clk); check("t1_pulse_end", dut_valid, 1'b0);
        check("t1_chk", chk_enable, 1'b1);
        check("t1_x_np1", tb_X_np1, 64'd7);
        @(negedge clk); check("t1_cnt", {issued_cnt, checked_cnt}, {16'd1, 16'd1});
        check("t1_busy", busy, 1'b0);
        @(posedge clk); #1;

        // Burst of 8 with no pops during the first fill.
        enable = 1'b0; gap = '0;
        fork
            send(8);
            begin
                repeat (6) @(negedge clk);
                check("burst_full_ready", vif.vec_ready, 1'b0);
                @(posedge clk); #1 enable = 1'b1;
            end
        join
        wait_idle();
        check("burst_cnt", {issued_cnt, checked_cnt}, {16'd9, 16'd9});

        // gap=3: pulses 4 cycles apart.
        enable = 1'b0; gap = 4'd3;
        send(3);
        enable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dut_valid) pulses.push_back(c);
        end
        check("gap_pulses", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("gap_space1", pulses[1] - pulses[0], 4);
            check("gap_space2", pulses[2] - pulses[1], 4);
        end
        wait_idle();

        // Enable stall mid-GAP with the delay line occupied.
        sent_q.delete();
        gap = 4'd3;
        send(3);
        enable = 1'b0;
        hold_x = sent_q[0].xn1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_chk", chk_enable, 1'b0);
            check("stall_dv", dut_valid, 1'b0);
            check("stall_hold_x", tb_X_np1, hold_x);
            check("stall_busy", busy, 1'b1);
        end
        @(posedge clk); #1 enable = 1'b1;
        wait_idle();
        check("stall_cnt", {issued_cnt, checked_cnt}, {16'd15, 16'd15});

        // srst with 3 vectors buffered and one in the delay line.
        gap = '0;
        send(1);
        @(posedge clk); #1;
        @(posedge clk); #1 enable = 1'b0;
        send(3);
        check("srst_pre_busy", busy, 1'b1);
        srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0;
        @(negedge clk);
        check("srst_cnt", {issued_cnt, checked_cnt}, 32'd0);
        check("srst_busy", busy, 1'b0);
        check("srst_ready", vif.vec_ready, 1'b1);
        @(posedge clk); #1 enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("srst_no_chk", chk_enable, 1'b0);
        end
        @(posedge clk); #1;

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            enable    = ($urandom_range(0, 99) < 85);
            vec_valid = 1'($urandom);
            drv       = rand_vec();
            gap       = ($urandom_range(0, 2) == 0) ? GAPW'($urandom_range(1, 3)) : '0;
            srst      = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        vec_valid = 1'b0; srst = 1'b0; enable = 1'b1; gap = '0;
        wait_idle();

        // Counter saturation.
        force dut.issued_cnt_q  = 16'hFFFE;
        force dut.checked_cnt_q = 16'hFFFE;
        #1;
        release dut.issued_cnt_q;
        release dut.checked_cnt_q;
        m_issued = 16'hFFFE; m_checked = 16'hFFFE;
        send(3);
        wait_idle();
        check("sat_issued", issued_cnt, 16'hFFFF);
        check("sat_checked", checked_cnt, 16'hFFFF);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
